// File: rtl/rf_alu_pkg.sv
// rf_alu_pkg: ALUOp/FuncCode encodings, ALU control enum and decoder.
package rf_alu_pkg;
  localparam logic [1:0] ALUOP_ADD = 2'b00;
  localparam logic [1:0] ALUOP_SUB = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;
  localparam logic [1:0] ALUOP_OR = 2'b11;
  localparam logic [5:0] FN_ADD = 6'd32;
  localparam logic [5:0] FN_SUB = 6'd34;
  localparam logic [5:0] FN_AND = 6'd36;
  localparam logic [5:0] FN_OR = 6'd37;
  localparam logic [5:0] FN_NOR = 6'd39;
  localparam logic [5:0] FN_SLT = 6'd42;
  localparam logic [5:0] FN_SLTU = 6'd43;
  typedef enum logic [2:0] {
    ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_NOR, ALU_SLT, ALU_SLTU, ALU_BAD
  } alu_ctl_e;
  function automatic alu_ctl_e alu_decode(input logic [1:0] op, input logic [5:0] fn);
    if (op == ALUOP_ADD) return ALU_ADD;
    if (op == ALUOP_SUB) return ALU_SUB;
    if (op == ALUOP_OR) return ALU_OR;
    case (fn)
      FN_ADD: return ALU_ADD;
      FN_SUB: return ALU_SUB;
      FN_AND: return ALU_AND;
      FN_OR: return ALU_OR;
      FN_NOR: return ALU_NOR;
      FN_SLT: return ALU_SLT;
      FN_SLTU: return ALU_SLTU;
      default: return ALU_BAD;
    endcase
  endfunction
endpackage

// File: rtl/rf_alu_pipe_alu_core.sv
// alu_core: combinational ALU with signed overflow and illegal-op flag.
module alu_core
  import rf_alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  alu_ctl_e         ctl,
  output logic [WIDTH-1:0] result,
  output logic             overflow,
  output logic             illegal
);
  logic [WIDTH-1:0] sum, dif;
  assign sum = a + b;
  assign dif = a - b;
  always_comb begin
    result = '0;
    overflow = 1'b0;
    illegal = 1'b0;
    case (ctl)
      ALU_ADD: begin
        result = sum;
        overflow = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      end
      ALU_SUB: begin
        result = dif;
        overflow = (a[WIDTH-1] != b[WIDTH-1]) && (dif[WIDTH-1] != a[WIDTH-1]);
      end
      ALU_AND: result = a & b;
      ALU_OR: result = a | b;
      ALU_NOR: result = ~(a | b);
      ALU_SLT: result = {{(WIDTH-1){1'b0}}, $signed(a) < $signed(b)};
      ALU_SLTU: result = {{(WIDTH-1){1'b0}}, a < b};
      default: illegal = 1'b1;
    endcase
  end
endmodule

// File: rtl/rf_alu_pipe.sv
// rf_alu_pipe: two-stage register-file + ALU pipeline with forwarding,
// external load port and write-back.
module rf_alu_pipe
  import rf_alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int NREGS = 32,
  parameter int ADDR_W = $clog2(NREGS)
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              InValid,
  input  logic [ADDR_W-1:0] Read1,
  input  logic [ADDR_W-1:0] Read2,
  input  logic [ADDR_W-1:0] DestReg,
  input  logic              WB,
  input  logic [1:0]        ALUOp,
  input  logic [5:0]        FuncCode,
  input  logic              RegWrite,
  input  logic [ADDR_W-1:0] WriteReg,
  input  logic [WIDTH-1:0]  WriteData,
  output logic [WIDTH-1:0]  ALUOut,
  output logic              Zero,
  output logic              Overflow,
  output logic              IllegalOp,
  output logic              OutValid
);
  logic [WIDTH-1:0] regs [NREGS];
  logic s1_v, s1_wb;
  logic [ADDR_W-1:0] s1_dest;
  alu_ctl_e s1_ctl;
  logic [WIDTH-1:0] s1_a, s1_b, res, op_a, op_b;
  logic ovf, ill, wb_en, ext_en;
  alu_core #(.WIDTH(WIDTH)) u_alu (
    .a(s1_a), .b(s1_b), .ctl(s1_ctl), .result(res), .overflow(ovf), .illegal(ill)
  );
  assign wb_en = s1_v && s1_wb && s1_dest != '0 && !ill;
  assign ext_en = RegWrite && WriteReg != '0;
  // Forward exactly what lands in the register file on this edge.
  assign op_a = (wb_en && s1_dest == Read1) ? res :
                (ext_en && WriteReg == Read1) ? WriteData : regs[Read1];
  assign op_b = (wb_en && s1_dest == Read2) ? res :
                (ext_en && WriteReg == Read2) ? WriteData : regs[Read2];
  // Write-back is issued last so it wins a same-register conflict.
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else begin
      if (ext_en) regs[WriteReg] <= WriteData;
      if (wb_en) regs[s1_dest] <= res;
    end
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      s1_v <= 1'b0;
      s1_wb <= 1'b0;
      s1_dest <= '0;
      s1_ctl <= ALU_ADD;
      s1_a <= '0;
      s1_b <= '0;
      OutValid <= 1'b0;
      ALUOut <= '0;
      Zero <= 1'b0;
      Overflow <= 1'b0;
      IllegalOp <= 1'b0;
    end else begin
      s1_v <= InValid;
      if (InValid) begin
        s1_wb <= WB;
        s1_dest <= DestReg;
        s1_ctl <= alu_decode(ALUOp, FuncCode);
        s1_a <= op_a;
        s1_b <= op_b;
      end
      OutValid <= s1_v;
      if (s1_v) begin
        ALUOut <= res;
        Zero <= res == '0;
        Overflow <= ovf;
        IllegalOp <= ill;
      end
    end
endmodule

// File: doc/rf_alu_pipe.md
Name: rf_alu_pipe

Overview:
- Parametrised, two-stage pipelined successor to the single-cycle register-file + ALU datapath.
- Stage 1 reads two operands from an NREGS x WIDTH register file and latches them with the decoded ALU operation.
- Stage 2 computes the result, registers ALUOut/Zero/Overflow, and writes the result back to the register file.
- Includes result forwarding, an external load port, and invalid-operation flagging; it is the execute core for the upcoming pipelined datapath.

Parameters:
- WIDTH, 32, datapath and register width in bits (>=8).
- NREGS, 32, number of registers (power of 2, >=4).
- ADDR_W, $clog2(NREGS), register address width (derived; do not override).

Ports:
- clock  in  1  rising-edge clock.
- reset_n  in  1  asynchronous, active-low reset.
- InValid  in  1  issue an operation this cycle.
- Read1  in  ADDR_W  source register A.
- Read2  in  ADDR_W  source register B.
- DestReg  in  ADDR_W  destination register for write-back.
- WB  in  1  write the result back to DestReg.
- ALUOp  in  2  00 add, 01 sub, 10 decode FuncCode, 11 or.
- FuncCode  in  6  function code, used only when ALUOp=10.
- RegWrite  in  1  external write enable.
- WriteReg  in  ADDR_W  external write address.
- WriteData  in  WIDTH  external write data.
- ALUOut  out  WIDTH  registered result.
- Zero  out  1  registered (ALUOut == 0).
- Overflow  out  1  registered signed overflow; add/sub only, else 0.
- IllegalOp  out  1  registered; FuncCode not supported.
- OutValid  out  1  ALUOut and flags are valid this cycle.

Behaviour:
- Reset (async assert, sync release):
  - All registers cleared to 0.
  - Stage-1 valid and OutValid cleared; ALUOut, Zero, Overflow, IllegalOp = 0.
  - In-flight operations are discarded; no write-back occurs for them.
- Register 0 always reads 0; writes to it are ignored from every source, including forwarding.
- Cycle N: InValid=1 with operands. Edge N: stage 1 captures A, B, op, DestReg, WB.
- Edge N+1:
  - ALUOut, flags and OutValid=1 registered.
  - If WB=1 and DestReg!=0, the register file is written with the same value.
  - Latency is 2 cycles; throughput is 1 operation per cycle; there is no backpressure.
- When InValid=0, OutValid is 0 one cycle later; ALUOut and flags hold their previous values.
- Operand sources, highest priority first (applied per operand; dest/addr != 0 in all cases):
  - (1) Stage-1 ALU result, when stage 1 is valid, WB=1 and DestReg matches.
  - (2) WriteData, when RegWrite=1 and WriteReg matches.
  - (3) Register-file array.
- Same-edge write conflict to one register: pipeline write-back wins and the external write is dropped. External writes to other registers proceed normally.
- FuncCode decode (ALUOp=10):
  - 32 add, 34 sub, 36 and, 37 or, 39 nor, 42 slt (signed), 43 sltu.
  - Any other code: result 0, IllegalOp=1, write-back suppressed.
- Arithmetic is modulo 2^WIDTH.
- Overflow for add: operands share a sign and the result sign differs.
- Overflow for sub: operand signs differ and the result sign differs from A.
- slt/sltu produce 1 or 0, zero-extended to WIDTH.
- Zero reflects the registered ALUOut in every case, including illegal ops.

Decomposition:
- rf_alu_pkg holds:
  - ALUOp encodings (ALUOP_ADD, ALUOP_SUB, ALUOP_FUNCT, ALUOP_OR).
  - FuncCode constants (FN_ADD=32, FN_SUB=34, FN_AND=36, FN_OR=37, FN_NOR=39, FN_SLT=42, FN_SLTU=43).
  - Internal ALU-control enum.
- One sub-module, alu_core:
  - Combinational, parametrised by WIDTH.
  - Inputs: A, B, control. Outputs: result, overflow, illegal.
- The register file, forwarding and pipeline registers stay in the top level.

Test Plan:
- Load and add: RegWrite r5=32'h55555555, then r10=32'hAAAAAAAB. Issue add r5,r10 (ALUOp=10, Func=32) -> two cycles later ALUOut=0, Zero=1, Overflow=0, OutValid=1.
- Function sweep on the same operands, one per cycle:
  - sub -> AAAAAAAA, Overflow=1.
  - and -> 00000001.
  - or -> FFFFFFFF.
  - nor -> 0.
  - slt -> 0.
  - sltu -> 1.
  - Results appear back-to-back.
- Forwarding: r1=7, r2=3. Issue add r3=r1+r2 with WB, then next cycle add r4=r3+r3 with WB -> ALUOut 10 then 20; r4 reads 20.
- Write conflict and r0:
  - Issue op with dest r6, WB; at its write-back edge also RegWrite r6=0xDEAD -> r6 holds the ALU result.
  - Issue add dest r0, WB -> a later read of r0 returns 0.
- Illegal and reset: Func=50 with WB to r7 -> IllegalOp=1, ALUOut=0, Zero=1, r7 unchanged. Assert reset_n=0 mid-stream while an op is in stage 1 -> outputs immediately 0, OutValid=0, all registers read 0 after release.
- Parameter sweep: WIDTH=16, NREGS=8. Add 16'h7FFF+1 -> 16'h8000, Overflow=1. Read of r7 after RegWrite r7 works.
